blink_checker: RTL and testbench
================================

BLINK_CHECKER -- requirements
Module: blink_checker

Interface
REQ-001 SHALL have parameter FREQUENCY, default 25E6, clock frequency in Hz.
REQ-002 SHALL have parameter SECONDS, default 1, nominal toggle interval in seconds.
REQ-003 SHALL have parameter TOLERANCE, default 0, accepted deviation in clocks either side of EXP.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port blink_i, input, 1 bit: monitored toggling signal, asynchronous to clk_i.
REQ-007 SHALL have port clear_i, input, 1 bit: synchronous clear of sticky flags.
REQ-008 SHALL have port valid_o, output, 1 bit: one-cycle pulse when a toggle interval is measured.
REQ-009 SHALL have port period_o, output, 32 bits: last measured interval in clocks; held between valid_o pulses.
REQ-010 SHALL have port ok_o, output, 1 bit: last measured interval within window.
REQ-011 SHALL have port err_o, output, 1 bit: sticky; set by any out-of-window interval or timeout.
REQ-012 SHALL have port timeout_o, output, 1 bit: no toggle seen for more than EXP+TOLERANCE clocks.
REQ-013 SHALL have port edges_o, output, 16 bits: count of in-window intervals (see Configuration).

Function
REQ-014 SHALL define EXP = FREQUENCY*SECONDS+1 clocks, the interval between toggles of the team's blink generator.
REQ-015 SHALL synchronise blink_i through two flip-flops, then detect an edge on either polarity with a third register (edge pulse 3 clocks after the input change).
REQ-016 SHALL implement states WAIT_FIRST, MEASURE, TIMEOUT; reset state WAIT_FIRST.
REQ-017 WAIT_FIRST: on edge pulse, clear counter, go to MEASURE; no valid_o.
REQ-018 MEASURE: counter increments by 1 per clock; interval = clocks between consecutive edge pulses (edge pulses at cycles 10 and 15 give 5).
REQ-019 MEASURE, on edge pulse: period_o <= interval, valid_o = 1 next cycle, ok_o = (EXP-TOLERANCE <= interval <= EXP+TOLERANCE), err_o set if not ok, counter restarts; state stays MEASURE.
REQ-020 MEASURE, no edge and counter reaches EXP+TOLERANCE+1: go to TIMEOUT, set timeout_o and err_o, clear ok_o, no valid_o.
REQ-021 TIMEOUT: counter frozen; edge pulse clears timeout_o, restarts counter, returns to MEASURE without producing valid_o.
REQ-022 Counter SHALL be 32 bits and saturate, never wrap; EXP-TOLERANCE SHALL floor at 0.
REQ-023 clear_i SHALL clear err_o, timeout_o, ok_o and return to WAIT_FIRST; if an edge pulse occurs in the same cycle, clear wins and the edge is taken as the first edge (state MEASURE).
REQ-024 err_o SHALL stay set until clear_i or reset, regardless of later good intervals.

Reset
REQ-025 rst_ni low SHALL immediately force: state WAIT_FIRST, counter 0, synchroniser 0, valid_o 0, period_o 0, ok_o 0, err_o 0, timeout_o 0, edges_o 0.
REQ-026 Reset asserted mid-measurement SHALL discard the partial interval; the first edge after release is treated as the first edge.

Configuration
REQ-027 With macro BLINK_CHECKER_STATS_EN defined, edges_o SHALL increment (wrapping at 16 bits) on each valid_o with ok_o=1 and clear on clear_i.
REQ-028 Without BLINK_CHECKER_STATS_EN, edges_o SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification (FREQUENCY=8, SECONDS=1, TOLERANCE=1: EXP=9, window 8..10)
REQ-029 Toggle blink_i every 9 clocks, 5 toggles -> 4 valid_o pulses, period_o=9, ok_o=1, err_o=0, edges_o=4 (STATS_EN).
REQ-030 Intervals 9 then 12 -> second valid_o with period_o=12, ok_o=0, err_o=1; later 9-clock intervals keep err_o=1.
REQ-031 One toggle then none -> timeout_o=1 and err_o=1 exactly 11 clocks after the edge pulse; next toggle clears timeout_o, no valid_o.
REQ-032 Pulse clear_i coincident with an edge pulse after errors -> err_o=0, timeout_o=0, no valid_o; next 9-clock toggle gives valid_o, period_o=9.
REQ-033 Assert rst_ni low 4 clocks into a measurement -> all outputs 0 immediately; first post-reset toggle yields no valid_o.

Source files
------------

// File: rtl/blink_checker.sv
// blink_checker: measures the interval between toggles of an asynchronous
// blink signal and flags intervals outside EXP +/- TOLERANCE clocks, where
// EXP = FREQUENCY*SECONDS+1. A missing toggle raises timeout_o.
// Optional feature: define BLINK_CHECKER_STATS_EN to count in-window
// intervals on edges_o; otherwise edges_o is tied to zero.
//
// valid_o handshake: valid_o is a single-cycle strobe with no ready/backpressure.
// period_o and ok_o are meaningful in the valid_o cycle and hold their value
// until the next strobe (ok_o is additionally cleared by timeout or clear_i).
module blink_checker #(
  parameter int unsigned FREQUENCY = 25_000_000,
  parameter int unsigned SECONDS   = 1,
  parameter int unsigned TOLERANCE = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        blink_i,
  input  logic        clear_i,
  output logic        valid_o,
  output logic [31:0] period_o,
  output logic        ok_o,
  output logic        err_o,
  output logic        timeout_o,
  output logic [15:0] edges_o,
  output logic [1:0]  state_o
);

  // Window bounds computed wide, then clamped into the 32-bit counter range.
  localparam logic [63:0] EXP_W = 64'(FREQUENCY) * 64'(SECONDS) + 64'd1;
  localparam logic [63:0] HI_W  = EXP_W + 64'(TOLERANCE);
  localparam logic [63:0] LO_W  = (EXP_W > 64'(TOLERANCE)) ? (EXP_W - 64'(TOLERANCE)) : 64'd0;
  localparam logic [31:0] HI    = (HI_W > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : HI_W[31:0];
  localparam logic [31:0] LO    = (LO_W > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : LO_W[31:0];

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    TIMEOUT    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cnt_inc;
  logic        sync1_q, sync2_q, sync3_q;
  logic        edge_pulse;
  logic        in_window;
  logic        meas_take;
  logic        tmo_set;
  logic        tmo_clr;

  // Two-flop synchroniser plus a history flop for either-polarity edge detect.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= blink_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edge_pulse = sync2_q ^ sync3_q;

  // The counter holds clocks elapsed since the last edge pulse, so the edge
  // cycle itself loads 1 and the value at the next pulse is the interval.
  assign cnt_inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
  assign in_window = (cnt_q >= LO) && (cnt_q <= HI);

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WAIT_FIRST;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; clear_i overrides everything, but a coincident edge
  // is still taken as the first edge of a new measurement.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    meas_take = 1'b0;
    tmo_set   = 1'b0;
    tmo_clr   = 1'b0;
    if (clear_i) begin
      if (edge_pulse) begin
        state_d = MEASURE;
        cnt_d   = 32'd1;
      end else begin
        state_d = WAIT_FIRST;
        cnt_d   = 32'd0;
      end
    end else begin
      case (state_q)
        WAIT_FIRST: begin
          if (edge_pulse) begin
            state_d = MEASURE;
            cnt_d   = 32'd1;
          end
        end
        MEASURE: begin
          if (edge_pulse) begin
            meas_take = 1'b1;
            cnt_d     = 32'd1;
          end else if (cnt_q >= HI) begin
            state_d = TIMEOUT;
            tmo_set = 1'b1;
            cnt_d   = cnt_inc;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        TIMEOUT: begin
          if (edge_pulse) begin
            state_d = MEASURE;
            tmo_clr = 1'b1;
            cnt_d   = 32'd1;
          end
        end
        default: begin
          state_d = WAIT_FIRST;
          cnt_d   = 32'd0;
        end
      endcase
    end
  end

  // Result and flag registers: strobe, measured period, window verdict, sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o   <= 1'b0;
      period_o  <= 32'd0;
      ok_o      <= 1'b0;
      err_o     <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      valid_o <= meas_take;
      if (clear_i) begin
        ok_o      <= 1'b0;
        err_o     <= 1'b0;
        timeout_o <= 1'b0;
      end else begin
        if (meas_take) begin
          period_o <= cnt_q;
          ok_o     <= in_window;
          if (!in_window) begin
            err_o <= 1'b1;
          end
        end
        if (tmo_set) begin
          timeout_o <= 1'b1;
          err_o     <= 1'b1;
          ok_o      <= 1'b0;
        end
        if (tmo_clr) begin
          timeout_o <= 1'b0;
        end
      end
    end
  end

`ifdef BLINK_CHECKER_STATS_EN
  logic [15:0] edges_q;

  // Count in-window intervals; wraps naturally at 16 bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      edges_q <= 16'd0;
    end else if (clear_i) begin
      edges_q <= 16'd0;
    end else if (meas_take && in_window) begin
      edges_q <= edges_q + 16'd1;
    end
  end

  assign edges_o = edges_q;
`else
  assign edges_o = 16'd0;
`endif

  assign state_o = state_q;

endmodule

// File: tb/tb_blink_checker.sv
// tb_blink_checker: randomized and directed stimulus for blink_checker,
// checked every cycle against a timestamp-based reference model.
module tb_blink_checker;

  localparam int unsigned FREQUENCY = 8;
  localparam int unsigned SECONDS   = 1;
  localparam int unsigned TOLERANCE = 1;
  localparam int EXP = FREQUENCY * SECONDS + 1;
  localparam int LO  = (EXP > TOLERANCE) ? EXP - TOLERANCE : 0;
  localparam int HI  = EXP + TOLERANCE;
`ifdef BLINK_CHECKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_i;
  logic        rst_ni;
  logic        blink_i;
  logic        clear_i;
  logic        valid_o;
  logic [31:0] period_o;
  logic        ok_o;
  logic        err_o;
  logic        timeout_o;
  logic [15:0] edges_o;
  logic [1:0]  state_o;

  blink_checker #(
    .FREQUENCY(FREQUENCY),
    .SECONDS  (SECONDS),
    .TOLERANCE(TOLERANCE)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .blink_i  (blink_i),
    .clear_i  (clear_i),
    .valid_o  (valid_o),
    .period_o (period_o),
    .ok_o     (ok_o),
    .err_o    (err_o),
    .timeout_o(timeout_o),
    .edges_o  (edges_o),
    .state_o  (state_o)
  );

  // ---------------- clock ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Works on posedge timestamps: a toggle driven before posedge t is seen by
  // the checker at posedge t+2; intervals are differences of those timestamps.
  int          cyc;
  int          tog_at[$];
  bit          m_first, m_tmo, m_valid, m_ok, m_err;
  int          m_last;
  logic [31:0] m_period;
  logic [15:0] m_edges;

  int n_valid;
  int tmo_rise;
  bit prev_tmo;

  task automatic model_reset();
    m_first  = 1'b0;
    m_tmo    = 1'b0;
    m_valid  = 1'b0;
    m_ok     = 1'b0;
    m_err    = 1'b0;
    m_last   = 0;
    m_period = 32'd0;
    m_edges  = 16'd0;
    tog_at.delete();
    exp_q.delete();
    prev_tmo = 1'b0;
  endtask

  task automatic model_tick(input bit clr);
    bit det;
    int gap;
    det = 1'b0;
    if (tog_at.size() > 0 && tog_at[0] == cyc - 2) begin
      det = 1'b1;
      void'(tog_at.pop_front());
    end
    m_valid = 1'b0;
    if (clr) begin
      m_ok = 0; m_err = 0; m_tmo = 0; m_edges = 16'd0;
      m_first = det;
      m_last  = cyc;
    end else if (det) begin
      if (m_first && !m_tmo) begin
        gap      = cyc - m_last;
        m_valid  = 1'b1;
        m_period = 32'(gap);
        m_ok     = (gap >= LO) && (gap <= HI);
        if (!m_ok) m_err = 1'b1;
        if (m_ok && STATS) m_edges = m_edges + 16'd1;
        exp_q.push_back(m_period);
      end
      m_tmo   = 1'b0;
      m_first = 1'b1;
      m_last  = cyc;
    end else if (m_first && !m_tmo && (cyc - m_last) == HI) begin
      m_tmo = 1'b1;
      m_err = 1'b1;
      m_ok  = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("valid", 32'(valid_o), 32'(m_valid));
    chk("ok", 32'(ok_o), 32'(m_ok));
    chk("err", 32'(err_o), 32'(m_err));
    chk("timeout", 32'(timeout_o), 32'(m_tmo));
    chk("period", period_o, m_period);
    chk("edges", 32'(edges_o), 32'(m_edges));
    if (valid_o) begin
      n_valid++;
      if (exp_q.size() == 0) chk("sb_unexpected_valid", 32'd1, 32'd0);
      else chk("sb_period", period_o, exp_q.pop_front());
    end
    if (timeout_o && !prev_tmo) tmo_rise = cyc;
    prev_tmo = timeout_o;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_period"}, period_o, 32'd0);
    chk({tag, "_ok"}, 32'(ok_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout_o), 32'd0);
    chk({tag, "_edges"}, 32'(edges_o), 32'd0);
  endtask

  // ---------------- driver tasks (entered and left at negedge) ----------------
  task automatic cycle(input bit tog, input bit clr);
    if (tog) begin
      blink_i = ~blink_i;
      tog_at.push_back(cyc + 1);
    end
    clear_i = clr;
    @(posedge clk_i);
    cyc++;
    model_tick(clr);
    @(negedge clk_i);
    check_outputs();
    clear_i = 1'b0;
  endtask

  task automatic gap_toggle(input int n);
    cycle(1'b1, 1'b0);
    repeat (n - 1) cycle(1'b0, 1'b0);
  endtask

  task automatic reset_mid();
    #2;
    rst_ni = 1'b0;
    #1;
    check_zero("rst_async");
    model_reset();
    @(posedge clk_i); cyc++;
    @(posedge clk_i); cyc++;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base, t, gap, pos;
    bit clr;
    rst_ni   = 1'b0;
    blink_i  = 1'b0;
    clear_i  = 1'b0;
    cyc      = 0;
    n_valid  = 0;
    tmo_rise = -1;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_zero("reset");
    rst_ni = 1'b1;

    // Five toggles every 9 clocks -> four in-window intervals.
    base = n_valid;
    repeat (5) gap_toggle(9);
    chk("r029_count", 32'(n_valid - base), 32'd4);
    chk("r029_period", period_o, 32'd9);
    chk("r029_ok", 32'(ok_o), 32'd1);
    chk("r029_err", 32'(err_o), 32'd0);
    chk("r029_edges", 32'(edges_o), STATS ? 32'd4 : 32'd0);

    // Intervals 9, 9, 6 (too short), 9: err_o stays set after the bad one.
    gap_toggle(9);
    gap_toggle(6);
    gap_toggle(9);
    gap_toggle(9);
    chk("r030_err_sticky", 32'(err_o), 32'd1);
    chk("r030_ok_after", 32'(ok_o), 32'd1);
    chk("r030_period", period_o, 32'd9);

    // One toggle then silence -> timeout 11 clocks after the edge pulse cycle.
    tmo_rise = -1;
    cycle(1'b1, 1'b0);
    t = cyc;
    repeat (15) cycle(1'b0, 1'b0);
    chk("r031_delay", 32'(tmo_rise - (t + 1)), 32'd11);
    chk("r031_timeout", 32'(timeout_o), 32'd1);
    chk("r031_err", 32'(err_o), 32'd1);
    chk("r031_ok", 32'(ok_o), 32'd0);
    base = n_valid;
    gap_toggle(9);
    chk("r031_tmo_clr", 32'(timeout_o), 32'd0);
    chk("r031_no_valid", 32'(n_valid - base), 32'd0);

    // Clear coincident with an edge pulse, then a clean 9-clock interval.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    base = n_valid;
    cycle(1'b0, 1'b1);
    chk("r032_err", 32'(err_o), 32'd0);
    chk("r032_timeout", 32'(timeout_o), 32'd0);
    chk("r032_valid", 32'(valid_o), 32'd0);
    repeat (6) cycle(1'b0, 1'b0);
    gap_toggle(9);
    chk("r032_count", 32'(n_valid - base), 32'd1);
    chk("r032_period", period_o, 32'd9);
    chk("r032_ok", 32'(ok_o), 32'd1);

    // Reset 4 clocks into a measurement, with blink_i parked low.
    if (!blink_i) gap_toggle(9);
    cycle(1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b0);
    reset_mid();
    base = n_valid;
    gap_toggle(10);
    chk("r033_no_valid", 32'(n_valid - base), 32'd0);

    // Randomized intervals around and outside the window, with sporadic clears.
    for (int i = 0; i < 150; i++) begin
      gap = $urandom_range(4, 13);
      clr = ($urandom_range(0, 7) == 0);
      pos = $urandom_range(1, gap - 1);
      cycle(1'b1, 1'b0);
      for (int k = 1; k < gap; k++) cycle(1'b0, clr && (k == pos));
    end
    repeat (15) cycle(1'b0, 1'b0);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
